// File: rtl/traffic_pkg.sv
// Shared types and constants for the pedestrian-crossing controller:
// phase encoding, main-road lamp patterns and a duration sanity check.
package traffic_pkg;

   typedef enum logic [2:0] {
      ST_GREEN    = 3'd0,
      ST_YELLOW   = 3'd1,
      ST_RED_PRE  = 3'd2,
      ST_WALK     = 3'd3,
      ST_FLASH    = 3'd4,
      ST_RED_POST = 3'd5
   } state_t;

   localparam logic [2:0] LIGHT_RED    = 3'b100;
   localparam logic [2:0] LIGHT_YELLOW = 3'b010;
   localparam logic [2:0] LIGHT_GREEN  = 3'b001;

   // A duration is usable when it is at least one cycle and dur-1 fits the counter.
   function automatic bit dur_fits(input int dur, input int cnt_w);
      if (dur < 1 || cnt_w < 1) return 1'b0;
      if (cnt_w >= 31) return 1'b1;
      return ((dur - 1) >> cnt_w) == 0;
   endfunction

endpackage

// File: rtl/phase_timer.sv
// Down-counter for phase timing: loads a value, then counts down once per
// cycle and holds at zero until the next load.
module phase_timer #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             i_load,
   input  logic [CNT_W-1:0] i_load_val,
   output logic [CNT_W-1:0] o_value,
   output logic             o_zero
);

   logic [CNT_W-1:0] r_value;

   // Reset is applied by the owner through a load of the reset phase value.
   always_ff @(posedge clk) begin
      if (i_load) begin
         r_value <= i_load_val;
      end else if (r_value != '0) begin
         r_value <= r_value - CNT_W'(1);
      end
   end

   assign o_value = r_value;
   assign o_zero  = (r_value == '0);

endmodule

// File: rtl/traffic_light_ped_ctrl.sv
// Pedestrian-crossing controller: main-road head plus WALK / flashing
// DON'T-WALK, with a latched pedestrian request and programmable phase lengths.
module traffic_light_ped_ctrl
   import traffic_pkg::*;
#(
   parameter int GREEN_MIN  = 8,
   parameter int YELLOW_CYC = 3,
   parameter int ALLRED_CYC = 2,
   parameter int WALK_CYC   = 6,
   parameter int FLASH_CYC  = 8,
   parameter int FLASH_HALF = 2,
   parameter int CNT_W      = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             pedestrian_button,
   output logic [2:0]       main_light,
   output logic             walk,
   output logic             dont_walk,
   output logic             ped_pending,
   output logic [CNT_W-1:0] ped_countdown
);

   if (!(dur_fits(GREEN_MIN, CNT_W) && dur_fits(YELLOW_CYC, CNT_W) &&
         dur_fits(ALLRED_CYC, CNT_W) && dur_fits(WALK_CYC, CNT_W) &&
         dur_fits(FLASH_CYC, CNT_W) && dur_fits(FLASH_HALF, CNT_W))) begin : g_bad_params
      $error("traffic_light_ped_ctrl: a phase duration is < 1 or does not fit CNT_W");
   end

   localparam logic [CNT_W-1:0] L_GREEN  = CNT_W'(GREEN_MIN - 1);
   localparam logic [CNT_W-1:0] L_YELLOW = CNT_W'(YELLOW_CYC - 1);
   localparam logic [CNT_W-1:0] L_ALLRED = CNT_W'(ALLRED_CYC - 1);
   localparam logic [CNT_W-1:0] L_WALK   = CNT_W'(WALK_CYC - 1);
   localparam logic [CNT_W-1:0] L_FLASH  = CNT_W'(FLASH_CYC - 1);
   localparam logic [CNT_W-1:0] L_HALF   = CNT_W'(FLASH_HALF - 1);

   state_t           r_state;
   state_t           w_next;
   state_t           w_load_state;
   logic             w_load;
   logic [CNT_W-1:0] w_load_val;
   logic [CNT_W-1:0] w_cnt;
   logic             w_zero;
   logic             r_ped_pending;
   logic             r_flash_lvl;
   logic [CNT_W-1:0] r_flash_hcnt;
   logic             w_enter_flash;
   logic             w_enter_walk;

   phase_timer #(.CNT_W(CNT_W)) u_timer (
      .clk        (clk),
      .i_load     (w_load),
      .i_load_val (w_load_val),
      .o_value    (w_cnt),
      .o_zero     (w_zero)
   );

   always_ff @(posedge clk) begin
      if (rst) r_state <= ST_GREEN;
      else     r_state <= w_next;
   end

   // GREEN sees the live button too, so a press on its last cycle is not lost a cycle.
   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_GREEN:    if (w_zero && (r_ped_pending || pedestrian_button)) w_next = ST_YELLOW;
         ST_YELLOW:   if (w_zero) w_next = ST_RED_PRE;
         ST_RED_PRE:  if (w_zero) w_next = ST_WALK;
         ST_WALK:     if (w_zero) w_next = ST_FLASH;
         ST_FLASH:    if (w_zero) w_next = ST_RED_POST;
         ST_RED_POST: if (w_zero) w_next = ST_GREEN;
         default:     w_next = ST_GREEN;
      endcase
   end

   always_comb begin
      w_load_state = rst ? ST_GREEN : w_next;
      w_load       = rst || (w_next != r_state);
      w_load_val   = L_GREEN;
      case (w_load_state)
         ST_YELLOW:               w_load_val = L_YELLOW;
         ST_RED_PRE, ST_RED_POST: w_load_val = L_ALLRED;
         ST_WALK:                 w_load_val = L_WALK;
         ST_FLASH:                w_load_val = L_FLASH;
         default:                 w_load_val = L_GREEN;
      endcase
   end

   assign w_enter_walk  = (w_next == ST_WALK)  && (r_state != ST_WALK);
   assign w_enter_flash = (w_next == ST_FLASH) && (r_state != ST_FLASH);

   // Entering WALK serves the request, so it beats a press on the same edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_ped_pending <= 1'b0;
      end else if (w_enter_walk) begin
         r_ped_pending <= 1'b0;
      end else if (pedestrian_button && (r_state != ST_WALK)) begin
         r_ped_pending <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_flash_lvl  <= 1'b1;
         r_flash_hcnt <= '0;
      end else if (w_enter_flash) begin
         r_flash_lvl  <= 1'b1;
         r_flash_hcnt <= L_HALF;
      end else if (r_state == ST_FLASH) begin
         if (r_flash_hcnt == '0) begin
            r_flash_lvl  <= ~r_flash_lvl;
            r_flash_hcnt <= L_HALF;
         end else begin
            r_flash_hcnt <= r_flash_hcnt - CNT_W'(1);
         end
      end
   end

   always_comb begin
      main_light    = LIGHT_GREEN;
      walk          = 1'b0;
      dont_walk     = 1'b1;
      ped_countdown = '0;
      case (r_state)
         ST_YELLOW:               main_light = LIGHT_YELLOW;
         ST_RED_PRE, ST_RED_POST: main_light = LIGHT_RED;
         ST_WALK: begin
            main_light = LIGHT_RED;
            walk       = 1'b1;
            dont_walk  = 1'b0;
         end
         ST_FLASH: begin
            main_light    = LIGHT_RED;
            dont_walk     = r_flash_lvl;
            ped_countdown = w_cnt;
         end
         default: main_light = LIGHT_GREEN;
      endcase
   end

   assign ped_pending = r_ped_pending;

endmodule

// File: tb/tb_traffic_light_ped_ctrl.sv
// Directed bench for traffic_light_ped_ctrl with short phase lengths; every
// cycle's expected output vector goes through a scoreboard queue.
module tb_traffic_light_ped_ctrl;

   localparam int CNT_W = 8;

   logic             clk = 1'b0;
   logic             rst;
   logic             pedestrian_button;
   logic [2:0]       main_light;
   logic             walk;
   logic             dont_walk;
   logic             ped_pending;
   logic [CNT_W-1:0] ped_countdown;

   logic [13:0] exp_q[$];
   int          n_checks = 0;
   int          n_pass   = 0;

   traffic_light_ped_ctrl #(
      .GREEN_MIN  (4),
      .YELLOW_CYC (2),
      .ALLRED_CYC (1),
      .WALK_CYC   (3),
      .FLASH_CYC  (4),
      .FLASH_HALF (1),
      .CNT_W      (CNT_W)
   ) dut (
      .clk               (clk),
      .rst               (rst),
      .pedestrian_button (pedestrian_button),
      .main_light        (main_light),
      .walk              (walk),
      .dont_walk         (dont_walk),
      .ped_pending       (ped_pending),
      .ped_countdown     (ped_countdown)
   );

   always #5 clk = ~clk;

   // Expected vector layout: {main_light, walk, dont_walk, ped_pending, ped_countdown}
   function automatic logic [13:0] vec(input logic [2:0] l, input logic w, input logic dw,
                                       input logic p, input logic [7:0] cd);
      return {l, w, dw, p, cd};
   endfunction

   function automatic logic [13:0] v_g(input logic p);
      return vec(3'b001, 1'b0, 1'b1, p, 8'd0);
   endfunction

   function automatic logic [13:0] v_y(input logic p);
      return vec(3'b010, 1'b0, 1'b1, p, 8'd0);
   endfunction

   function automatic logic [13:0] v_r(input logic p);
      return vec(3'b100, 1'b0, 1'b1, p, 8'd0);
   endfunction

   function automatic logic [13:0] v_w();
      return vec(3'b100, 1'b1, 1'b0, 1'b0, 8'd0);
   endfunction

   function automatic logic [13:0] v_f(input logic dw, input logic [7:0] cd, input logic p);
      return vec(3'b100, 1'b0, dw, p, cd);
   endfunction

   // Drive inputs for one cycle, queue what the next edge must produce, check it.
   task automatic tick(input string tag, input logic r, input logic b, input logic [13:0] e);
      logic [13:0] exp_v;
      logic [13:0] obs;
      rst               = r;
      pedestrian_button = b;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      exp_v = exp_q.pop_front();
      obs   = {main_light, walk, dont_walk, ped_pending, ped_countdown};
      n_checks++;
      assert (obs === exp_v) n_pass++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
   endtask

   // One full pedestrian service starting from GREEN with cnt==0 and a request in hand.
   task automatic serve(input string tag, input logic b0, input logic bwalk, input logic bflash);
      tick({tag, "_y1"},  1'b0, b0,     v_y(1'b1));
      tick({tag, "_y2"},  1'b0, 1'b0,   v_y(1'b1));
      tick({tag, "_rp"},  1'b0, 1'b0,   v_r(1'b1));
      tick({tag, "_w1"},  1'b0, 1'b0,   v_w());
      tick({tag, "_w2"},  1'b0, bwalk,  v_w());
      tick({tag, "_w3"},  1'b0, bwalk,  v_w());
      tick({tag, "_f1"},  1'b0, bwalk,  v_f(1'b1, 8'd3, 1'b0));
      tick({tag, "_f2"},  1'b0, bflash, v_f(1'b0, 8'd2, bflash));
      tick({tag, "_f3"},  1'b0, bflash, v_f(1'b1, 8'd1, bflash));
      tick({tag, "_f4"},  1'b0, bflash, v_f(1'b0, 8'd0, bflash));
      tick({tag, "_rpo"}, 1'b0, 1'b0,   v_r(bflash));
   endtask

   initial begin
      rst               = 1'b1;
      pedestrian_button = 1'b0;

      // Reset, then idle: GREEN held with no request.
      for (int i = 0; i < 3; i++)  tick("s1_rst", 1'b1, 1'b0, v_g(1'b0));
      for (int i = 0; i < 50; i++) tick("s1_idle", 1'b0, 1'b0, v_g(1'b0));

      // Press one cycle after reset release: GREEN lasts GREEN_MIN cycles from reset.
      tick("s2_rst",   1'b1, 1'b0, v_g(1'b0));
      tick("s2_g2",    1'b0, 1'b0, v_g(1'b0));
      tick("s2_press", 1'b0, 1'b1, v_g(1'b1));
      tick("s2_g4",    1'b0, 1'b0, v_g(1'b1));
      serve("s2", 1'b0, 1'b0, 1'b0);
      tick("s2_back",  1'b0, 1'b0, v_g(1'b0));

      // Presses only during WALK are ignored; GREEN is held afterwards.
      tick("s3_press", 1'b0, 1'b1, v_g(1'b1));
      tick("s3_g3",    1'b0, 1'b0, v_g(1'b1));
      tick("s3_g4",    1'b0, 1'b0, v_g(1'b1));
      serve("s3", 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 12; i++) tick("s3_hold", 1'b0, 1'b0, v_g(1'b0));

      // Press during FLASH stays latched and forces the next cycle after GREEN_MIN.
      serve("s4", 1'b1, 1'b0, 1'b1);
      for (int i = 0; i < 4; i++) tick("s4_green", 1'b0, 1'b0, v_g(1'b1));
      serve("s4b", 1'b0, 1'b0, 1'b0);

      // Press exactly on the cycle GREEN reaches cnt 0, no prior request.
      for (int i = 0; i < 4; i++) tick("s5_green", 1'b0, 1'b0, v_g(1'b0));
      serve("s5", 1'b1, 1'b0, 1'b0);

      // Reset mid-WALK, then confirm the GREEN timer restarts from GREEN_MIN.
      tick("s6_g1",   1'b0, 1'b0, v_g(1'b0));
      tick("s6_g2",   1'b0, 1'b1, v_g(1'b1));
      tick("s6_g3",   1'b0, 1'b0, v_g(1'b1));
      tick("s6_g4",   1'b0, 1'b0, v_g(1'b1));
      tick("s6_y1",   1'b0, 1'b0, v_y(1'b1));
      tick("s6_y2",   1'b0, 1'b0, v_y(1'b1));
      tick("s6_rp",   1'b0, 1'b0, v_r(1'b1));
      tick("s6_w1",   1'b0, 1'b0, v_w());
      tick("s6_rst",  1'b1, 1'b1, v_g(1'b0));
      tick("s6_rg2",  1'b0, 1'b1, v_g(1'b1));
      tick("s6_rg3",  1'b0, 1'b1, v_g(1'b1));
      tick("s6_rg4",  1'b0, 1'b0, v_g(1'b1));
      tick("s6_ry1",  1'b0, 1'b0, v_y(1'b1));

      // Reset during FLASH clears the countdown and flash output.
      tick("s7_y2",   1'b0, 1'b0, v_y(1'b1));
      tick("s7_rp",   1'b0, 1'b0, v_r(1'b1));
      tick("s7_w1",   1'b0, 1'b0, v_w());
      tick("s7_w2",   1'b0, 1'b0, v_w());
      tick("s7_w3",   1'b0, 1'b0, v_w());
      tick("s7_f1",   1'b0, 1'b0, v_f(1'b1, 8'd3, 1'b0));
      tick("s7_f2",   1'b0, 1'b0, v_f(1'b0, 8'd2, 1'b0));
      tick("s7_rst",  1'b1, 1'b0, v_g(1'b0));
      tick("s7_idle", 1'b0, 1'b0, v_g(1'b0));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
